alu_mul_seq: RTL and testbench
==============================

// Module: alu_mul_seq
// PURPOSE
//  Iterative shift-add multiplier sequencer that borrows the shared ALU (ADD, AluOp=4'd0) to form MUL results.
//  Sits beside the ALU: asserts AluSel to request the ALU, drives AluOp/AluA/AluB, consumes AluOut.
//  Yields the low n bits of MulA*MulB (RV32 MUL semantics; identical for signed and unsigned operands).
//  Advances only on cycles where the owner of the ALU mux grants access (AluGnt).
// PARAMETERS
//  n  32  operand/result width; iteration count = n
// PORTS
//  clock    in   1  single clock; all state changes on rising edge
//  nReset   in   1  asynchronous, active-low reset
//  start    in   1  request a multiply; sampled only in IDLE
//  MulA     in   n  multiplicand; captured on accepted start
//  MulB     in   n  multiplier; captured on accepted start
//  AluGnt   in   1  ALU granted to this block this cycle
//  AluOut   in   n  result from the shared ALU (AluA+AluB)
//  AluSel   out  1  ALU request; high in RUN only
//  AluOp    out  4  always 4'd0 (ADD)
//  AluA     out  n  accumulator P in RUN, else 0
//  AluB     out  n  shifted multiplicand M in RUN, else 0
//  busy     out  1  high when state != IDLE
//  done     out  1  one-cycle pulse in DONE
//  Product  out  n  registered result; held until the next accepted start
// BEHAVIOUR
//  Reset (nReset=0, immediate): state=IDLE, P=M=Q=0, count=0, Product=0; done=busy=AluSel=0, AluA=AluB=0.
//  States: IDLE -> RUN -> DONE -> IDLE.
//  IDLE: if start=1 at edge: P<=0, M<=MulA, Q<=MulB, count<=0, state<=RUN; otherwise hold.
//  RUN, AluGnt=1 at edge: if Q[0] then P<=AluOut; M<=M<<1 (MSB dropped); Q<=Q>>1 (zero fill); count<=count+1.
//    - When count==n-1 at that edge: Product<=(Q[0]?AluOut:P), state<=DONE.
//  RUN, AluGnt=0: all of P, M, Q, count hold; AluSel stays high; AluA/AluB stay valid.
//  DONE: done=1 for exactly one cycle; state<=IDLE at next edge. Product already valid in DONE.
//  start is ignored in RUN and DONE; there is no abort, and no queueing of a start seen while busy.
//  Latency with AluGnt held high: start accepted at edge E0; done high between edges En and En+1.
//    - Each cycle of AluGnt=0 during RUN adds exactly one cycle.
//  Fixed n iterations; no early exit on Q==0. count is $clog2(n)+1 bits wide.
//  Arithmetic: mod 2^n; overflow is discarded silently; no flags. AluOut is combinational from the ALU.
//  AluOp, AluA and AluB are functions of state only (not of AluGnt), so the ALU path has no comb loop.
//  Reset mid-RUN: abort immediately to IDLE; Product=0; no done pulse.
//  Product changes only on the final RUN edge or on reset; it never changes on start acceptance.
// TESTING
//  1. AluGnt=1, MulA=7, MulB=6, start one cycle -> busy 1 for n+1 cycles, done pulse 32 edges after E0, Product=42.
//  2. MulA=32'hFFFF_FFFF, MulB=32'hFFFF_FFFF -> Product=32'h0000_0001 (wrap).
//     MulA=32'h0001_0000, MulB=32'h0001_0000 -> Product=0.
//  3. MulA=0 or MulB=0 -> still 32 RUN cycles, Product=0, done pulse once.
//     MulA=32'h8000_0000, MulB=1 -> Product=32'h8000_0000.
//  4. AluGnt low for 5 random RUN cycles; MulA=123, MulB=456 -> done 5 cycles late, Product=56088.
//     AluSel stays high and P holds while AluGnt=0.
//  5. start held high continuously -> ops accepted only from IDLE, one per n+2 cycles.
//     Product stable between done pulses.
//  6. nReset low at RUN cycle 10 -> outputs 0 asynchronously, no done pulse.
//     A new start after release gives a correct Product.

Source files
------------

// File: rtl/alu_mul_seq_if.sv
// alu_mul_seq_if
//   Bundles the multiply request/result signals and the shared-ALU borrow
//   signals of alu_mul_seq.
//   Request side : start, MulA, MulB in; busy, done, Product out.
//   ALU side     : AluGnt, AluOut in; AluSel, AluOp, AluA, AluB out.
//   Modport slave is the multiplier; modport master is whoever drives it.
//
// Handshakes:
//   - A multiply is accepted on a rising edge where start=1 and the block
//     is idle (busy=0). A start seen while busy is dropped, not queued.
//   - One shift-add step happens on each rising edge where AluSel=1 and
//     AluGnt=1. While AluGnt=0 the request and operands are held.
interface alu_mul_seq_if #(
  parameter int n = 32
);
  logic         start;
  logic [n-1:0] MulA;
  logic [n-1:0] MulB;
  logic         busy;
  logic         done;
  logic [n-1:0] Product;
  logic         AluGnt;
  logic [n-1:0] AluOut;
  logic         AluSel;
  logic [3:0]   AluOp;
  logic [n-1:0] AluA;
  logic [n-1:0] AluB;

  modport slave (
    input  start, MulA, MulB, AluGnt, AluOut,
    output busy, done, Product, AluSel, AluOp, AluA, AluB
  );

  modport master (
    output start, MulA, MulB, AluGnt, AluOut,
    input  busy, done, Product, AluSel, AluOp, AluA, AluB
  );
endinterface

// File: rtl/alu_mul_seq.sv
// alu_mul_seq
//   Iterative shift-add multiplier that borrows a shared ALU (ADD) for the
//   accumulate step. It produces the low n bits of MulA*MulB. This result is
//   the same for signed and unsigned operands.
//   Ports:
//     clock     rising-edge clock
//     nReset    asynchronous active-low reset
//     mif       alu_mul_seq_if.slave (request/result and ALU borrow signals)
//     dbg_state current FSM state (0=IDLE, 1=RUN, 2=DONE)
module alu_mul_seq #(
  parameter int n = 32
) (
  input  logic               clock,
  input  logic               nReset,
  alu_mul_seq_if.slave       mif,
  output logic [1:0]         dbg_state
);

  localparam int CW = $clog2(n) + 1;
  localparam logic [CW-1:0] LAST = CW'(n - 1);

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    RUN  = 2'd1,
    DONE = 2'd2
  } state_t;

  state_t        state;
  logic [n-1:0]  p;        // partial-product accumulator
  logic [n-1:0]  m;        // multiplicand, shifted left each step
  logic [n-1:0]  q;        // multiplier, shifted right each step
  logic [CW-1:0] count;
  logic [n-1:0]  product_q;
  logic          busy_q;
  logic          done_q;
  logic          sel_q;    // registered copy of (state == RUN)

  always_ff @(posedge clock or negedge nReset) begin
    if (!nReset) begin
      state     <= IDLE;
      p         <= '0;
      m         <= '0;
      q         <= '0;
      count     <= '0;
      product_q <= '0;
      busy_q    <= 1'b0;
      done_q    <= 1'b0;
      sel_q     <= 1'b0;
    end else begin
      case (state)
        IDLE: begin
          if (mif.start) begin
            p      <= '0;
            m      <= mif.MulA;
            q      <= mif.MulB;
            count  <= '0;
            state  <= RUN;
            busy_q <= 1'b1;
            sel_q  <= 1'b1;
          end
        end
        RUN: begin
          // No grant means nothing moves. The ALU inputs stay stable, so
          // the next granted cycle sees the same sum.
          if (mif.AluGnt) begin
            if (q[0]) p <= mif.AluOut;
            m     <= m << 1;
            q     <= q >> 1;
            count <= count + CW'(1);
            if (count == LAST) begin
              // The last add is still in flight in AluOut. Take it directly
              // rather than waiting a cycle for p to update.
              product_q <= q[0] ? mif.AluOut : p;
              state     <= DONE;
              sel_q     <= 1'b0;
              done_q    <= 1'b1;
            end
          end
        end
        DONE: begin
          state  <= IDLE;
          done_q <= 1'b0;
          busy_q <= 1'b0;
        end
        default: begin
          state  <= IDLE;
          done_q <= 1'b0;
          busy_q <= 1'b0;
          sel_q  <= 1'b0;
        end
      endcase
    end
  end

  // The ALU drive depends only on registered state, never on AluGnt.
  // This keeps any grant logic downstream of AluSel from forming a loop.
  assign mif.AluSel  = sel_q;
  assign mif.AluOp   = 4'd0;
  assign mif.AluA    = sel_q ? p : '0;
  assign mif.AluB    = sel_q ? m : '0;
  assign mif.busy    = busy_q;
  assign mif.done    = done_q;
  assign mif.Product = product_q;
  assign dbg_state   = state;

endmodule

// File: tb/tb_alu_mul_seq.sv
module tb_alu_mul_seq;

  localparam int N = 32;

  logic       clock;
  logic       nReset;
  logic [1:0] dbg_state;

  alu_mul_seq_if #(.n(N)) mif ();

  // Shared ALU stand-in: ADD only.
  assign mif.AluOut = mif.AluA + mif.AluB;

  alu_mul_seq #(.n(N)) dut (
    .clock     (clock),
    .nReset    (nReset),
    .mif       (mif),
    .dbg_state (dbg_state)
  );

  // ---------------- clock / reset ----------------
  initial begin
    clock = 1'b0;
    forever #5 clock = ~clock;
  end

  int tests_run = 0;
  int tests_failed = 0;
  logic [N-1:0] exp_q[$];

  task automatic check_val(input string tag, input logic [N-1:0] got,
                           input logic [N-1:0] exp);
    tests_run++;
    if (got !== exp) begin
      tests_failed++;
      $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
    end
  endtask

  task automatic tick();
    @(posedge clock);
    #1;
  endtask

  // ---------------- driver: one multiply ----------------
  // stalls = number of RUN cycles with AluGnt=0. These are spread at
  // random over the first 20 RUN cycles.
  task automatic run_mul(input logic [N-1:0] a, input logic [N-1:0] b,
                         input logic [N-1:0] exp, input int stalls);
    logic [63:0]  mask;
    logic [N-1:0] hold_a;
    int           pos;
    int           k;
    int           busy_cnt;
    logic         seen;
    mask = '0;
    for (int i = 0; i < stalls; i++) begin
      do pos = $urandom_range(1, 20); while (mask[pos]);
      mask[pos] = 1'b1;
    end
    exp_q.push_back(exp);
    mif.MulA  = a;
    mif.MulB  = b;
    mif.start = 1'b1;
    tick();                       // edge E0: accepted
    mif.start = 1'b0;
    busy_cnt = mif.busy ? 1 : 0;
    k = 0;
    seen = 1'b0;
    while (!seen && k < 200) begin
      k++;
      mif.AluGnt = (k < 64) ? !mask[k] : 1'b1;
      hold_a = mif.AluA;
      tick();
      if (mif.busy) busy_cnt++;
      if (k < 64 && mask[k]) begin
        check_val("stall_alusel", N'(mif.AluSel), N'(1));
        check_val("stall_p_hold", mif.AluA, hold_a);
      end
      if (mif.done) seen = 1'b1;
    end
    mif.AluGnt = 1'b1;
    check_val("done_seen", N'(seen), N'(1));
    check_val("latency", N'(k), N'(N + stalls));
    check_val("busy_cycles", N'(busy_cnt), N'(N + 1 + stalls));
    check_val("product", mif.Product, exp_q.pop_front());
    tick();
    check_val("done_one_cycle", N'(mif.done), N'(0));
    check_val("idle_after", N'(mif.busy), N'(0));
    check_val("product_held", mif.Product, exp);
  endtask

  // ---------------- stimulus ----------------
  initial begin
    int           k;
    int           dones;
    logic         stable;

    nReset     = 1'b0;
    mif.start  = 1'b0;
    mif.MulA   = '0;
    mif.MulB   = '0;
    mif.AluGnt = 1'b1;
    #12;
    check_val("rst_busy", N'(mif.busy), N'(0));
    check_val("rst_done", N'(mif.done), N'(0));
    check_val("rst_alusel", N'(mif.AluSel), N'(0));
    check_val("rst_alua", mif.AluA, '0);
    check_val("rst_alub", mif.AluB, '0);
    check_val("rst_product", mif.Product, '0);
    check_val("rst_state", N'(dbg_state), N'(0));
    check_val("aluop", N'(mif.AluOp), N'(0));
    nReset = 1'b1;
    tick();

    // basic, wrap and boundary products
    run_mul(32'd7, 32'd6, 32'd42, 0);
    run_mul(32'hFFFF_FFFF, 32'hFFFF_FFFF, 32'h0000_0001, 0);
    run_mul(32'h0001_0000, 32'h0001_0000, 32'h0, 0);
    run_mul(32'h0, 32'h1234_5678, 32'h0, 0);
    run_mul(32'hDEAD_BEEF, 32'h0, 32'h0, 0);
    run_mul(32'h8000_0000, 32'h1, 32'h8000_0000, 0);
    run_mul(32'd1000, 32'd1000, 32'd1000000, 0);

    // grant withdrawn for 5 RUN cycles
    run_mul(32'd123, 32'd456, 32'd56088, 5);

    // start held high: accepted only from IDLE, one per N+2 cycles
    mif.MulA  = 32'd3;
    mif.MulB  = 32'd5;
    mif.start = 1'b1;
    k = 0;
    while (!mif.done && k < 200) begin
      tick();
      k++;
    end
    check_val("held_first_done", N'(mif.done), N'(1));
    check_val("held_first_prod", mif.Product, 32'd15);
    mif.MulA = 32'd10;
    mif.MulB = 32'd11;
    k = 0;
    stable = 1'b1;
    do begin
      tick();
      k++;
      if (!mif.done && mif.Product !== 32'd15) stable = 1'b0;
    end while (!mif.done && k < 200);
    mif.start = 1'b0;
    check_val("held_spacing", N'(k), N'(N + 2));
    check_val("held_prod_stable", N'(stable), N'(1));
    check_val("held_second_prod", mif.Product, 32'd110);
    tick();
    tick();
    check_val("held_back_idle", N'(mif.busy), N'(0));

    // reset at RUN cycle 10
    mif.MulA  = 32'd3;
    mif.MulB  = 32'd3;
    mif.start = 1'b1;
    tick();
    mif.start = 1'b0;
    for (int i = 0; i < 10; i++) tick();
    check_val("pre_rst_busy", N'(mif.busy), N'(1));
    #1 nReset = 1'b0;
    #1;
    check_val("arst_busy", N'(mif.busy), N'(0));
    check_val("arst_alusel", N'(mif.AluSel), N'(0));
    check_val("arst_alua", mif.AluA, '0);
    check_val("arst_product", mif.Product, '0);
    check_val("arst_state", N'(dbg_state), N'(0));
    tick();
    nReset = 1'b1;
    dones = 0;
    for (int i = 0; i < 40; i++) begin
      tick();
      if (mif.done) dones++;
    end
    check_val("no_done_after_rst", N'(dones), N'(0));
    run_mul(32'd9, 32'd13, 32'd117, 0);

    $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
    $finish;
  end

endmodule
